spectrum_peak_tracker: RTL and testbench
========================================

Name: spectrum_peak_tracker

Overview:
- Parametrised successor to the two-peak spectrum measurement block.
- Consumes one FFT magnitude frame streamed bin by bin from the spectrum RAM read-out.
- Tracks the NUM_PEAKS largest qualified local maxima in each frame, ranked by magnitude.
- At frame end it publishes amplitude and frequency per rank for the VGA/display path. Amplitude uses hysteresis to stabilise the display.

Parameters:
- DATA_W, 10, magnitude width.
- ADDR_W, 10, bin index width; a frame holds 2^ADDR_W bins.
- NUM_PEAKS, 2, number of ranked peak slots (1..8).
- FREQ_W, 20, frequency output width.
- MIN_RISE, 5, a peak must exceed its older neighbour by more than this.
- HYST, 3, minimum amplitude change that updates a published amplitude.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  starts a new frame; clears working state
- bin_valid  in  1  bin_mag/bin_idx valid this cycle
- bin_idx  in  ADDR_W  bin address, increments by 1 per valid sample
- bin_mag  in  DATA_W  bin magnitude
- res_sel  in  2  frequency resolution: 0→1, 1→10, 2→100, 3→1000 Hz/bin
- peak_amp  out  NUM_PEAKS*(DATA_W+2)  flattened amplitudes; rank 0 in the LSBs
- peak_freq  out  NUM_PEAKS*FREQ_W  flattened frequencies; rank 0 in the LSBs
- peak_cnt  out  4  number of valid peaks in the last frame
- result_valid  out  1  one-cycle pulse when outputs update
- busy  out  1  high in SCAN or COMMIT

Behaviour:
- Reset is synchronous on rst_n=0. All outputs are 0, the FSM goes to IDLE, and the working table and window are cleared.
- FSM states:
  - IDLE: on frame_start go to SCAN.
  - SCAN: on a valid sample with bin_idx = 2^ADDR_W-1, go to COMMIT.
  - COMMIT: lasts one cycle, then goes to IDLE.
- frame_start in any state clears the window and the working table and enters SCAN. If bin_valid is asserted in the same cycle, that sample belongs to the new frame.
- bin_valid is ignored in IDLE and COMMIT.
- Window: a 3-tap shift (w0 newest, w1, w2) with the index of w1 tracked; it shifts only on bin_valid.
- Candidate rule: w1 is a candidate when w1>w0, w1>w2 and w1-w2>MIN_RISE. The rule is evaluated after the window holds 3 frame samples, so bins 0 and 2^ADDR_W-1 are never peaks.
- Working table: NUM_PEAKS slots sorted by descending magnitude.
  - A candidate is inserted in rank order, lower ranks shift down, and the last slot is dropped.
  - A candidate smaller than or equal to a full table's last slot is discarded.
  - Ties: the earlier (lower-index) bin keeps the higher rank.
- Insertion takes effect on the cycle after the candidate is detected. The last bin's candidate, if any, is settled before COMMIT samples the table.
- COMMIT, per rank k:
  - freq = idx_k × res, where res is res_sel sampled in COMMIT; it saturates to all-ones if it exceeds FREQ_W bits.
  - The stored amplitude updates only when |amp_k − held_k| ≥ HYST. The frequency always updates.
  - Empty slots publish amp 0 and freq 0; the empty-slot amplitude bypasses hysteresis.
  - peak_cnt = number of filled slots.
- result_valid pulses one cycle after COMMIT, aligned with the new outputs. Latency from the last-bin sample to result_valid is 2 cycles.
- An aborted frame (frame_start before the last bin) publishes nothing.
- Outputs hold between frames.

Optional Feature:
- SPF_AMP_SCALE_EN defined: published amplitude = (held×125)>>5, i.e. ×3.906 volts-display scaling, using DATA_W+7 bit intermediate arithmetic.
- Undefined: published amplitude = held, zero-extended to DATA_W+2.
- Hysteresis always compares unscaled values.

Decomposition:
- Package spf_pkg holds:
  - the FSM state enum (IDLE, SCAN, COMMIT);
  - the resolution constants 1/10/100/1000;
  - the res_sel decode function;
  - a peak-slot struct {mag, idx}.
- One sub-module, spf_sorted_insert, implements the NUM_PEAKS-slot insertion table with clear, insert and read.

Test Plan:
- Frame with bins 100=200 and 300=500, rest 10, res_sel=0 → rank0 amp 500 / freq 300; rank1 amp 200 / freq 100; peak_cnt=2; result_valid 2 cycles after bin 1023.
- Same frame with res_sel=3 → rank0 freq 300000, rank1 freq 100000. With ADDR_W=12 and a peak at bin 4000 → freq saturates to 1048575.
- Rise of exactly MIN_RISE (bin 50 = 15 on a floor of 10) → no peak; 16 → peak detected. Equal twin peaks of 400 at bins 20 and 40 → bin 20 is rank0.
- Second frame with amplitudes 502 and 197 against held 500 and 200 → amp 500 stays, 197 updates (Δ=3); both frequencies refresh.
- frame_start at bin 600 mid-frame, then a full clean frame → exactly one result_valid, reflecting only the second frame. rst_n low mid-frame → all outputs 0, busy 0.
- NUM_PEAKS=4 with 6 peaks of magnitudes 100..600 → the top four are published in descending order. With SPF_AMP_SCALE_EN, amp 512 → 2000.

Source files
------------

// File: rtl/spf_pkg.sv
// Shared types and constants for the spectrum peak tracker: FSM state
// encoding, frequency-resolution constants and decode, and the peak-slot record.
package spf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } spf_state_t;

   localparam int RES_W = 10;
   localparam logic [RES_W-1:0] RES_1    = 10'd1;
   localparam logic [RES_W-1:0] RES_10   = 10'd10;
   localparam logic [RES_W-1:0] RES_100  = 10'd100;
   localparam logic [RES_W-1:0] RES_1000 = 10'd1000;

   // Slot fields are wide enough for any supported DATA_W / ADDR_W (<= 16).
   localparam int SLOT_FIELD_W = 16;

   typedef struct packed {
      logic [SLOT_FIELD_W-1:0] mag;
      logic [SLOT_FIELD_W-1:0] idx;
   } peak_slot_t;

   function automatic logic [RES_W-1:0] res_decode(input logic [1:0] sel);
      case (sel)
         2'd0:    return RES_1;
         2'd1:    return RES_10;
         2'd2:    return RES_100;
         default: return RES_1000;
      endcase
   endfunction

endpackage

// File: rtl/spf_sorted_insert.sv
// Ranked peak table: NUM_PEAKS slots kept in descending magnitude order.
// A new entry lands in front of the first empty or strictly smaller slot, so
// an equal later entry ranks below an earlier one; the last slot falls off.
module spf_sorted_insert
   import spf_pkg::*;
#(
   parameter int NUM_PEAKS = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic                             ins_en,
   input  peak_slot_t                       ins_slot,
   output peak_slot_t [NUM_PEAKS-1:0]       slots,
   output logic       [NUM_PEAKS-1:0]       slot_vld
);

   logic       [NUM_PEAKS-1:0] take;
   peak_slot_t [NUM_PEAKS-1:0] slots_nxt;
   logic       [NUM_PEAKS-1:0] vld_nxt;

   // Find the insertion rank and build the shifted table.
   always_comb begin
      take      = '0;
      slots_nxt = slots;
      vld_nxt   = slot_vld;
      for (int k = 0; k < NUM_PEAKS; k++) begin
         take[k] = !slot_vld[k] || (ins_slot.mag > slots[k].mag);
      end
      if (take[0]) begin
         slots_nxt[0] = ins_slot;
         vld_nxt[0]   = 1'b1;
      end
      for (int k = 1; k < NUM_PEAKS; k++) begin
         if (take[k]) begin
            slots_nxt[k] = take[k-1] ? slots[k-1] : ins_slot;
            vld_nxt[k]   = take[k-1] ? slot_vld[k-1] : 1'b1;
         end
      end
   end

   // Table register: clear dominates insert.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         slots    <= '0;
         slot_vld <= '0;
      end else if (ins_en) begin
         slots    <= slots_nxt;
         slot_vld <= vld_nxt;
      end
   end

endmodule

// File: rtl/spectrum_peak_tracker.sv
// Spectrum peak tracker: scans one FFT magnitude frame, keeps the NUM_PEAKS
// largest qualified local maxima and publishes amplitude/frequency per rank
// with amplitude hysteresis. Optional macro SPF_AMP_SCALE_EN enables the
// x125/32 display scaling of published amplitudes.
module spectrum_peak_tracker
   import spf_pkg::*;
#(
   parameter int DATA_W    = 10,
   parameter int ADDR_W    = 10,
   parameter int NUM_PEAKS = 2,
   parameter int FREQ_W    = 20,
   parameter int MIN_RISE  = 5,
   parameter int HYST      = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             frame_start,
   input  logic                             bin_valid,
   input  logic [ADDR_W-1:0]                bin_idx,
   input  logic [DATA_W-1:0]                bin_mag,
   input  logic [1:0]                       res_sel,
   output logic [NUM_PEAKS*(DATA_W+2)-1:0]  peak_amp,
   output logic [NUM_PEAKS*FREQ_W-1:0]      peak_freq,
   output logic [3:0]                       peak_cnt,
   output logic                             result_valid,
   output logic                             busy
);

   localparam int AMP_W  = DATA_W + 2;
   localparam int PROD_W = SLOT_FIELD_W + RES_W;
   localparam logic [ADDR_W-1:0] LAST_BIN = '1;

   spf_state_t                             state;
   logic       [DATA_W-1:0]                win_w1;
   logic       [DATA_W-1:0]                win_w2;
   logic       [ADDR_W-1:0]                win_w1_idx;
   logic       [1:0]                       fill;
   logic signed [DATA_W:0]                 rise_p0;
   logic                                   cand_vld_p0;
   logic                                   ins_en;
   peak_slot_t                             ins_slot;
   peak_slot_t [NUM_PEAKS-1:0]             slots;
   logic       [NUM_PEAKS-1:0]             slot_vld;
   logic       [DATA_W-1:0]                held [NUM_PEAKS];
   logic       [NUM_PEAKS-1:0][FREQ_W-1:0] freq_r;
   logic       [RES_W-1:0]                 res;

   function automatic logic hyst_pass(input logic [SLOT_FIELD_W-1:0] mag,
                                      input logic [DATA_W-1:0] h);
      logic signed [SLOT_FIELD_W:0] diff;
      diff = $signed({1'b0, mag}) - $signed({1'b0, SLOT_FIELD_W'(h)});
      if (diff[SLOT_FIELD_W]) diff = -diff;
      return diff >= (SLOT_FIELD_W+1)'(HYST);
   endfunction

   function automatic logic [FREQ_W-1:0] sat_freq(input logic [PROD_W-1:0] p);
      if ((p >> FREQ_W) != '0) return '1;
      return FREQ_W'(p);
   endfunction

   function automatic logic [AMP_W-1:0] scale_amp(input logic [DATA_W-1:0] h);
`ifdef SPF_AMP_SCALE_EN
      logic [DATA_W+6:0] t;
      t = (DATA_W+7)'(h) * (DATA_W+7)'(125);
      return AMP_W'(t >> 5);
`else
      return AMP_W'(h);
`endif
   endfunction

   function automatic logic [3:0] count_vld(input logic [NUM_PEAKS-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int k = 0; k < NUM_PEAKS; k++) c = c + 4'(v[k]);
      return c;
   endfunction

   // Stage p0: the live sample is the newest tap; w1 is the candidate bin.
   assign rise_p0     = $signed({1'b0, win_w1}) - $signed({1'b0, win_w2});
   assign cand_vld_p0 = (fill == 2'd2) && (win_w1 > bin_mag) && (win_w1 > win_w2) &&
                        (rise_p0 > (DATA_W+1)'(MIN_RISE));
   assign ins_en       = (state == SCAN) && bin_valid && !frame_start && cand_vld_p0;
   assign ins_slot.mag = SLOT_FIELD_W'(win_w1);
   assign ins_slot.idx = SLOT_FIELD_W'(win_w1_idx);
   assign res          = res_decode(res_sel);

   // Stage p1: ranked table, settled by the time COMMIT reads it.
   spf_sorted_insert #(
      .NUM_PEAKS (NUM_PEAKS)
   ) u_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (frame_start),
      .ins_en   (ins_en),
      .ins_slot (ins_slot),
      .slots    (slots),
      .slot_vld (slot_vld)
   );

   // Frame FSM, sample window and result publishing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         win_w1       <= '0;
         win_w2       <= '0;
         win_w1_idx   <= '0;
         fill         <= '0;
         freq_r       <= '0;
         peak_cnt     <= '0;
         result_valid <= 1'b0;
         for (int k = 0; k < NUM_PEAKS; k++) held[k] <= '0;
      end else begin
         result_valid <= 1'b0;
         if (frame_start) begin
            state      <= SCAN;
            win_w2     <= '0;
            win_w1     <= bin_valid ? bin_mag : '0;
            win_w1_idx <= bin_idx;
            fill       <= bin_valid ? 2'd1 : 2'd0;
         end else begin
            case (state)
               SCAN: begin
                  if (bin_valid) begin
                     win_w2     <= win_w1;
                     win_w1     <= bin_mag;
                     win_w1_idx <= bin_idx;
                     if (fill != 2'd2) fill <= fill + 2'd1;
                     if (bin_idx == LAST_BIN) state <= COMMIT;
                  end
               end
               COMMIT: begin
                  state        <= IDLE;
                  result_valid <= 1'b1;
                  peak_cnt     <= count_vld(slot_vld);
                  for (int k = 0; k < NUM_PEAKS; k++) begin
                     if (slot_vld[k]) begin
                        freq_r[k] <= sat_freq(PROD_W'(slots[k].idx) * PROD_W'(res));
                        if (hyst_pass(slots[k].mag, held[k]))
                           held[k] <= slots[k].mag[DATA_W-1:0];
                     end else begin
                        freq_r[k] <= '0;
                        held[k]   <= '0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Stage p2: published view of the held results.
   for (genvar k = 0; k < NUM_PEAKS; k++) begin : g_amp
      assign peak_amp[k*AMP_W +: AMP_W] = scale_amp(held[k]);
   end

   assign peak_freq = freq_r;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_spectrum_peak_tracker.sv
// Directed bench for spectrum_peak_tracker: three instances (default,
// ADDR_W=12, NUM_PEAKS=4) share the bin stream; each has its own frame_start.
module tb_spectrum_peak_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fs_a, fs_b, fs_c;
   logic        bin_valid;
   logic [11:0] bin_idx;
   logic [9:0]  bin_mag;
   logic [1:0]  res_sel;

   logic [23:0] amp_a, amp_b;
   logic [39:0] freq_a, freq_b;
   logic [47:0] amp_c;
   logic [79:0] freq_c;
   logic [3:0]  cnt_a, cnt_b, cnt_c;
   logic        rv_a, rv_b, rv_c;
   logic        busy_a, busy_b, busy_c;

   int errors = 0;
   int checks = 0;
   int pulses_a = 0;
   int p0;
   int fr [4096];

   always #5 clk = ~clk;

   // Count result pulses of the default instance.
   always @(posedge clk) if (rv_a === 1'b1) pulses_a <= pulses_a + 1;

   spectrum_peak_tracker u_a (
      .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .bin_valid(bin_valid),
      .bin_idx(bin_idx[9:0]), .bin_mag(bin_mag), .res_sel(res_sel),
      .peak_amp(amp_a), .peak_freq(freq_a), .peak_cnt(cnt_a),
      .result_valid(rv_a), .busy(busy_a));

   spectrum_peak_tracker #(.ADDR_W(12)) u_b (
      .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .bin_valid(bin_valid),
      .bin_idx(bin_idx), .bin_mag(bin_mag), .res_sel(res_sel),
      .peak_amp(amp_b), .peak_freq(freq_b), .peak_cnt(cnt_b),
      .result_valid(rv_b), .busy(busy_b));

   spectrum_peak_tracker #(.NUM_PEAKS(4)) u_c (
      .clk(clk), .rst_n(rst_n), .frame_start(fs_c), .bin_valid(bin_valid),
      .bin_idx(bin_idx[9:0]), .bin_mag(bin_mag), .res_sel(res_sel),
      .peak_amp(amp_c), .peak_freq(freq_c), .peak_cnt(cnt_c),
      .result_valid(rv_c), .busy(busy_c));

   function automatic logic [11:0] ea(input int v);
`ifdef SPF_AMP_SCALE_EN
      return 12'((v * 125) >>> 5);
`else
      return 12'(v);
`endif
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_floor();
      for (int i = 0; i < 4096; i++) fr[i] = 10;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive bins [first, last_excl) to one instance; frame_start rides on bin 0.
   task automatic run_frame(input int dut, input int first, input int last_excl,
                            input logic [1:0] rs);
      res_sel = rs;
      for (int i = first; i < last_excl; i++) begin
         fs_a      = (dut == 0) && (i == 0);
         fs_b      = (dut == 1) && (i == 0);
         fs_c      = (dut == 2) && (i == 0);
         bin_valid = 1'b1;
         bin_idx   = 12'(i);
         bin_mag   = 10'(fr[i]);
         tick();
      end
      fs_a = 1'b0; fs_b = 1'b0; fs_c = 1'b0;
      bin_valid = 1'b0;
   endtask

   function automatic logic sel_rv(input int dut);
      return (dut == 0) ? rv_a : (dut == 1) ? rv_b : rv_c;
   endfunction

   function automatic logic sel_busy(input int dut);
      return (dut == 0) ? busy_a : (dut == 1) ? busy_b : busy_c;
   endfunction

   // Called right after the last bin edge: COMMIT cycle, then the pulse.
   task automatic end_frame(input int dut);
      chk("commit_rv_low", sel_rv(dut), 1'b0);
      chk("commit_busy", sel_busy(dut), 1'b1);
      tick();
      chk("result_valid_pulse", sel_rv(dut), 1'b1);
   endtask

   task automatic after_pulse(input int dut);
      tick();
      chk("result_valid_drop", sel_rv(dut), 1'b0);
      chk("idle_busy", sel_busy(dut), 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; fs_a = 1'b0; fs_b = 1'b0; fs_c = 1'b0;
      bin_valid = 1'b0; bin_idx = '0; bin_mag = '0; res_sel = 2'd0;
      repeat (3) tick();
      chk("rst_amp_a", amp_a, 24'd0);
      chk("rst_freq_a", freq_a, 40'd0);
      chk("rst_cnt_a", cnt_a, 4'd0);
      chk("rst_rv_a", rv_a, 1'b0);
      chk("rst_busy_a", busy_a, 1'b0);
      chk("rst_amp_c", amp_c, 48'd0);
      chk("rst_busy_b", busy_b, 1'b0);
      rst_n = 1'b1;
      tick();

      // Two peaks, 1 Hz/bin
      set_floor(); fr[100] = 200; fr[300] = 500;
      run_frame(0, 0, 1024, 2'd0);
      end_frame(0);
      chk("f1_amp", amp_a, {ea(200), ea(500)});
      chk("f1_freq", freq_a, {20'd100, 20'd300});
      chk("f1_cnt", cnt_a, 4'd2);
      after_pulse(0);

      // Same frame at 1000 Hz/bin; outputs hold during the scan
      run_frame(0, 0, 512, 2'd3);
      chk("f2_hold_freq", freq_a, {20'd100, 20'd300});
      chk("f2_scan_busy", busy_a, 1'b1);
      run_frame(0, 512, 1024, 2'd3);
      end_frame(0);
      chk("f2_freq", freq_a, {20'd100000, 20'd300000});
      chk("f2_amp", amp_a, {ea(200), ea(500)});
      after_pulse(0);

      // Hysteresis: 502 vs held 500 holds, 197 vs held 200 updates
      set_floor(); fr[100] = 197; fr[300] = 502;
      run_frame(0, 0, 1024, 2'd0);
      end_frame(0);
      chk("f3_amp_hyst", amp_a, {ea(197), ea(500)});
      chk("f3_freq", freq_a, {20'd100, 20'd300});
      after_pulse(0);

      // Rise of exactly MIN_RISE is not a peak
      set_floor(); fr[50] = 15;
      run_frame(0, 0, 1024, 2'd0);
      end_frame(0);
      chk("f4_cnt_none", cnt_a, 4'd0);
      chk("f4_amp_empty", amp_a, 24'd0);
      chk("f4_freq_empty", freq_a, 40'd0);
      after_pulse(0);

      // One more than MIN_RISE is a peak
      set_floor(); fr[50] = 16;
      run_frame(0, 0, 1024, 2'd0);
      end_frame(0);
      chk("f5_cnt", cnt_a, 4'd1);
      chk("f5_amp", amp_a, {ea(0), ea(16)});
      chk("f5_freq", freq_a, {20'd0, 20'd50});
      after_pulse(0);

      // Equal twins: earlier bin ranks first
      set_floor(); fr[20] = 400; fr[40] = 400;
      run_frame(0, 0, 1024, 2'd0);
      end_frame(0);
      chk("f6_tie_freq", freq_a, {20'd40, 20'd20});
      chk("f6_tie_amp", amp_a, {ea(400), ea(400)});
      after_pulse(0);

      // Aborted frame at bin 600, then a clean frame
      p0 = pulses_a;
      set_floor(); fr[100] = 900;
      run_frame(0, 0, 600, 2'd0);
      chk("abort_no_pulse", pulses_a, p0);
      set_floor(); fr[200] = 250; fr[700] = 350;
      run_frame(0, 0, 1024, 2'd0);
      end_frame(0);
      chk("abort_amp", amp_a, {ea(250), ea(350)});
      chk("abort_freq", freq_a, {20'd200, 20'd700});
      chk("abort_cnt", cnt_a, 4'd2);
      after_pulse(0);
      chk("abort_one_pulse", pulses_a, p0 + 1);

      // 4096-bin frame: bin 4000 x1000 saturates, bin 1000 x1000 fits
      set_floor(); fr[1000] = 200; fr[4000] = 300;
      run_frame(1, 0, 4096, 2'd3);
      end_frame(1);
      chk("b_freq_sat", freq_b, {20'd1000000, 20'd1048575});
      chk("b_amp", amp_b, {ea(200), ea(300)});
      after_pulse(1);

      // Four slots, six peaks: top four in descending order, 10 Hz/bin
      set_floor();
      fr[100] = 300; fr[200] = 100; fr[300] = 600;
      fr[400] = 200; fr[500] = 500; fr[600] = 400;
      run_frame(2, 0, 1024, 2'd1);
      end_frame(2);
      chk("c_amp", amp_c, {ea(300), ea(400), ea(500), ea(600)});
      chk("c_freq", freq_c, {20'd1000, 20'd6000, 20'd5000, 20'd3000});
      chk("c_cnt", cnt_c, 4'd4);
      after_pulse(2);

      // Reset mid-frame clears everything
      set_floor();
      run_frame(0, 0, 300, 2'd0);
      chk("pre_rst_busy", busy_a, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_amp_a", amp_a, 24'd0);
      chk("mid_rst_freq_a", freq_a, 40'd0);
      chk("mid_rst_cnt_a", cnt_a, 4'd0);
      chk("mid_rst_busy_a", busy_a, 1'b0);
      chk("mid_rst_rv_a", rv_a, 1'b0);
      chk("mid_rst_amp_c", amp_c, 48'd0);
      chk("mid_rst_freq_b", freq_b, 40'd0);
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
